// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers fetched words for decode, handles branch redirects.
// Optional FETCH_PERF_EN macro adds saturating fetch/stall performance counters.
module fetch_unit #(
    parameter int PC_W = 8,
    parameter int IMM_W = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_instr,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [31:0]      if_instr,
    output logic [PC_W-1:0]  if_pc,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_pc,
    input  logic [IMM_W-1:0] br_imm,
    output logic             halted,
    output logic             fault,
    output logic [15:0]      fetch_cnt,
    output logic [15:0]      stall_cnt
);

    typedef enum logic {RUN, HALT} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] if_pc_q, if_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic            free;
    logic [PC_W-1:0] br_target;

    // Output register can take a new word if empty or being consumed on this edge.
    assign free = !valid_q || if_ready;

    always_comb begin
        br_target = PC_W'({{PC_W{br_imm[IMM_W-1]}}, br_imm, 1'b0}
                          + {{(IMM_W + 1){1'b0}}, br_pc});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            if_pc_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_pc_q <= if_pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if_pc_d = if_pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        case (state_q)
            RUN: begin
                if (br_taken) begin
                    valid_d = 1'b0;
                    if (br_target[1:0] == 2'b00) begin
                        pc_d = br_target;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end
                end else if (free) begin
                    if (imem_instr != '0) begin
                        instr_d = imem_instr;
                        if_pc_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + PC_W'(4);
                    end else begin
                        valid_d = 1'b0;
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (if_ready) valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign imem_addr = pc_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = if_pc_q;
    assign halted    = (state_q == HALT);
    assign fault     = fault_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (valid_q && if_ready && fetch_cnt_q != '1)
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (valid_q && !if_ready && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: reference model predicts delivered words, monitor checks each handshake.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic        br_taken = 1'b0;
    logic [7:0]  br_pc = '0;
    logic [11:0] br_imm = '0;
    logic        halted, fault;
    logic [15:0] fetch_cnt, stall_cnt;

    logic [31:0] mem [64];

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[7:2]];

    fetch_unit #(.PC_W(8), .IMM_W(12), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc),
        .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm),
        .halted(halted), .fault(fault),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [7:0]  pc;
    } item_t;

    item_t sb[$];
    item_t got;
    int    checks = 0;
    int    errors = 0;

    // Reference model: fetch address, whether decode holds an undelivered word, halt/fault flags.
    int mpc;
    bit mheld, mhalt, mfault;
    int mfc, msc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("imem_addr", imem_addr, mpc);
        chk("if_valid", if_valid, mheld);
        chk("halted", halted, mhalt);
        chk("fault", fault, mfault);
`ifdef FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt, mfc);
        chk("stall_cnt", stall_cnt, msc);
`else
        chk("fetch_cnt", fetch_cnt, 0);
        chk("stall_cnt", stall_cnt, 0);
`endif
    endtask

    // Predict the effect of the next clock edge given the inputs now applied.
    task automatic model_step();
        bit          cons = mheld && if_ready;
        int          t;
        logic [31:0] w;
        if (mheld && if_ready && mfc < 65535) mfc++;
        if (mheld && !if_ready && msc < 65535) msc++;
        if (mhalt) begin
            if (cons) mheld = 0;
        end else if (br_taken) begin
            if (mheld && !cons) void'(sb.pop_back());
            mheld = 0;
            t = (int'(br_pc) + 2 * int'($signed(br_imm))) & 255;
            if (t % 4 == 0) mpc = t;
            else begin
                mhalt  = 1;
                mfault = 1;
            end
        end else if (!mheld || cons) begin
            w = mem[mpc / 4];
            if (w != 0) begin
                sb.push_back({w, 8'(mpc)});
                mheld = 1;
                mpc = (mpc + 4) % 256;
            end else begin
                mheld = 0;
                mhalt = 1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit b, input logic [7:0] bp, input logic [11:0] bi);
        @(posedge clk);
        #1;
        check_state();
        if_ready = r;
        br_taken = b;
        br_pc    = bp;
        br_imm   = bi;
        model_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", if_valid, 0);
        chk("rst_async_halted", halted, 0);
        chk("rst_async_fault", fault, 0);
        chk("rst_async_addr", imem_addr, 8'h00);
        @(posedge clk);
        #1;
        sb.delete();
        mpc = 0; mheld = 0; mhalt = 0; mfault = 0; mfc = 0; msc = 0;
        chk("rst_if_instr", if_instr, 0);
        chk("rst_if_pc", if_pc, 0);
        check_state();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        br_taken = 1'b0;
        model_step();
    endtask

    task automatic fill_mem(input int zero_div);
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            do w = $urandom; while (w == 0);
            if (zero_div > 0 && $urandom_range(0, zero_div - 1) == 0) w = '0;
            mem[i] = w;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && if_valid === 1'b1 && if_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery actual_pc=%h expected=none at %0t", if_pc, $time);
            end else begin
                got = sb.pop_front();
                chk("deliver_instr", if_instr, got.instr);
                chk("deliver_pc", if_pc, got.pc);
            end
        end
    end

    initial begin
        logic [7:0]  bp;
        logic [11:0] bi;

        // Short program ending in a zero word.
        fill_mem(0);
        mem[0] = 32'h00500093; mem[1] = 32'h00100113;
        mem[2] = 32'h002081B3; mem[3] = 32'h00000000;
        do_reset();
        repeat (6) cycle(1, 0, 0, 0);

        // Same program, decode stalls three cycles after the first capture.
        do_reset();
        repeat (3) cycle(0, 0, 0, 0);
        chk("stall_hold_instr", if_instr, 32'h00500093);
        chk("stall_hold_pc", if_pc, 8'h00);
        repeat (6) cycle(1, 0, 0, 0);

        // Branch back to 0 while the word at 8 is presented, then refetch.
        fill_mem(0);
        do_reset();
        repeat (2) cycle(1, 0, 0, 0);
        cycle(1, 1, 8'h08, 12'hFFC);
        repeat (4) cycle(1, 0, 0, 0);

        // Misaligned target faults; later redirects are ignored.
        cycle(1, 1, 8'h04, 12'h001);
        repeat (3) cycle(1, 1, 8'h00, 12'h000);
        repeat (2) cycle(1, 0, 0, 0);

        // Redirect to F8 and run across the address wrap.
        do_reset();
        cycle(1, 1, 8'h00, 12'hFFC);
        repeat (6) cycle(1, 0, 0, 0);

        // Reset asserted during a stall with a valid word held.
        repeat (3) cycle(0, 0, 0, 0);
        do_reset();

        // Randomized episodes.
        for (int ep = 0; ep < 12; ep++) begin
            fill_mem(48);
            do_reset();
            for (int c = 0; c < 150; c++) begin
                bp = 8'($urandom);
                if ($urandom_range(0, 6) != 0) bp[1:0] = 2'b00;
                bi = 12'($urandom);
                if ($urandom_range(0, 6) != 0) bi[0] = 1'b0;
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, bp, bi);
            end
        end

        @(posedge clk);
        #1;
        check_state();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the 8-bit byte address into instruction memory.
- Captures the returned 32-bit little-endian-assembled instruction into a valid/ready output register for decode.
- Handles taken-branch redirects and flushes the output register on a redirect; halts on an all-zero instruction word or on a misaligned branch target.

Parameters:
- PC_W, 8, program-counter and instruction-memory address width (byte address).
- IMM_W, 12, width of the signed branch immediate (B-format, in half-word units).
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  PC_W  byte address to instruction memory; combinational copy of the PC register.
- imem_instr  input  32  instruction word returned by instruction memory for imem_addr (combinational).
- if_valid  output  1  output register holds a valid instruction.
- if_ready  input  1  decode accepts the output register this cycle.
- if_instr  output  32  fetched instruction.
- if_pc  output  PC_W  byte address of if_instr.
- br_taken  input  1  single-cycle pulse from execute: redirect the PC.
- br_pc  input  PC_W  address of the branch instruction.
- br_imm  input  IMM_W  signed branch immediate in half-words.
- halted  output  1  fetch stopped (end of program or fault).
- fault  output  1  halted because of a misaligned branch target.
- fetch_cnt  output  16  instructions delivered to decode (FETCH_PERF_EN).
- stall_cnt  output  16  cycles with if_valid=1 and if_ready=0 (FETCH_PERF_EN).

Behaviour:
- Reset (asynchronous, while rst_n=0): PC=RESET_PC; state=RUN; if_valid=0; if_instr=0; if_pc=0; halted=0; fault=0; counters=0. Reset asserted mid-operation discards everything immediately.
- States: RUN and HALT.
  - RUN→HALT: zero-instruction capture or misaligned target (below).
  - HALT exits only on reset.
- Output register is "free" when if_valid=0, or when if_valid=1 and if_ready=1 (consumed this edge).
- RUN, no br_taken, register free, imem_instr≠0:
  - Load if_instr=imem_instr and if_pc=PC; set if_valid=1.
  - PC ← PC+4, modulo 2^PC_W (8'hFC wraps to 8'h00 silently).
  - Latency: an instruction at address A appears on if_instr one clock after the PC equals A.
- RUN, register free, imem_instr==32'h0: do not present the word; if_valid←0; halted←1; state←HALT; PC unchanged.
- RUN, if_valid=1 and if_ready=0 (stall): PC, if_instr, if_pc and if_valid all hold.
- Branch redirect (br_taken=1, RUN): highest priority, evaluated regardless of stall or if_ready.
  - Target = br_pc + (sign-extended br_imm << 1), truncated to PC_W.
  - if_valid←0 (flush). A word presented with if_ready=1 in the same cycle is still counted as consumed by decode.
  - Target[1:0]==0: PC←target.
  - Target[1:0]≠0: PC holds; fault←1; halted←1; state←HALT.
- HALT:
  - No PC updates; br_taken ignored.
  - A valid word remaining in the output register still drains normally via if_ready; it is not re-filled.
  - halted and fault hold until reset.
- Simultaneous events: br_taken together with a zero-instruction capture takes the branch path; the zero word is not evaluated that cycle.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - fetch_cnt increments on every edge with if_valid=1 and if_ready=1.
  - stall_cnt increments on every edge with if_valid=1 and if_ready=0.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Memory words 0x00500093, 0x00100113, 0x002081B3, 0x00000000 at 0/4/8/12; if_ready=1 → if_pc 0,4,8 on consecutive cycles with matching if_instr; halted=1 after capture attempt at 12; if_valid=0 thereafter.
- Same program with if_ready=0 for 3 cycles after the first capture → if_instr=0x00500093 and if_pc=0 held; imem_addr stays 4; stall_cnt=3 (FETCH_PERF_EN).
- With if_pc=8 valid, pulse br_taken, br_pc=8, br_imm=-4 → if_valid=0 next cycle; PC=0; refetch of address 0 follows.
- br_taken, br_pc=4, br_imm=1 (target 6) → fault=1, halted=1; further br_taken pulses ignored; imem_addr frozen.
- RESET_PC=8'hF8, nonzero words everywhere → if_pc sequence F8, FC, 00, 04 (wrap-around).
- Assert rst_n=0 mid-stall with if_valid=1 → if_valid, halted and fault drop to 0 immediately, without waiting for a clock; PC=RESET_PC.
